// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding imem fetch with 2-entry in-order buffer and redirect flush; optional INSTR_FETCH_MISALIGN_CHECK_EN
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state, n_state;
  logic [31:0] fetch_pc, n_pc, n_addr, tgt;
  logic [31:0] i1, p1, n_i0, n_p0, n_i1, n_p1;
  logic [1:0] cnt, c1, n_cnt;
  logic ack, pop, push, bad, n_mis, issue, go;
  assign imem_req = state != IDLE;
  assign instr_valid = cnt != 2'd0;
  assign ack = imem_req & imem_ack;
  assign pop = instr_valid & instr_ready & ~redirect;
  assign push = ack & (state == REQ) & ~redirect;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign tgt = redirect_pc;
  assign bad = redirect & |redirect_pc[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) fetch_misaligned <= 1'b0;
    else fetch_misaligned <= n_mis;
`else
  assign tgt = redirect_pc & ~32'd3;
  assign bad = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif
  always_comb begin
    c1 = cnt - {1'b0, pop};
    n_i0 = pop ? i1 : instr;
    n_p0 = pop ? p1 : instr_pc;
    n_i1 = i1;
    n_p1 = p1;
    if (push && c1 == 2'd0) begin
      n_i0 = imem_rdata;
      n_p0 = imem_addr;
    end
    if (push && c1 != 2'd0) begin
      n_i1 = imem_rdata;
      n_p1 = imem_addr;
    end
    n_cnt = redirect ? 2'd0 : c1 + {1'b0, push};
    n_mis = fetch_misaligned | bad;
    n_pc = redirect ? tgt : push ? fetch_pc + 32'd4 : fetch_pc;
    issue = !n_mis && n_cnt != 2'd2;
    // a new request may start only once nothing is in flight
    go = state == IDLE || ack;
    n_state = go ? (issue ? REQ : IDLE) : redirect ? DROP : state;
    n_addr = go && issue ? n_pc : imem_addr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      imem_addr <= RESET_PC;
      cnt <= 2'd0;
      instr <= '0;
      instr_pc <= '0;
      i1 <= '0;
      p1 <= '0;
    end else begin
      state <= n_state;
      fetch_pc <= n_pc;
      imem_addr <= n_addr;
      cnt <= n_cnt;
      instr <= n_i0;
      instr_pc <= n_p0;
      i1 <= n_i1;
      p1 <= n_p1;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven directed check of instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] K = 32'hDEAD_0000;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack, instr_valid, instr_ready, redirect, fetch_misaligned;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;
  instr_fetch #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_misaligned(fetch_misaligned)
  );
  typedef struct {
    logic rdy, ack, redir;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
    logic mis;
  } vec_t;
  vec_t v [18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc, input logic mis);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, valid});
    chk({tag, ".mis"}, {31'd0, fetch_misaligned}, {31'd0, mis});
    if (valid) begin
      chk({tag, ".pc"}, instr_pc, pc);
      chk({tag, ".instr"}, instr, pc ^ K);
    end
  endtask
  task automatic step(input logic rdy, input logic ack, input logic redir, input logic [31:0] rpc);
    instr_ready = rdy;
    imem_ack = ack;
    redirect = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    instr_ready = 0; imem_ack = 0; redirect = 0; redirect_pc = 0;
    v[0]  = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0};
    v[1]  = '{1, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 0};
    v[2]  = '{1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104, 0};
    v[3]  = '{1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h108, 0};
    v[4]  = '{0, 1, 0, 32'h0,   0, 32'h10C, 1, 32'h108, 0};
    v[5]  = '{0, 1, 0, 32'h0,   0, 32'h10C, 1, 32'h108, 0};
    v[6]  = '{1, 1, 0, 32'h0,   1, 32'h110, 1, 32'h10C, 0};
    v[7]  = '{1, 1, 0, 32'h0,   1, 32'h114, 1, 32'h110, 0};
    v[8]  = '{1, 1, 1, 32'h40,  1, 32'h40,  0, 32'h0,   0};
    v[9]  = '{1, 1, 0, 32'h0,   1, 32'h44,  1, 32'h40,  0};
    v[10] = '{1, 0, 0, 32'h0,   1, 32'h44,  0, 32'h0,   0};
    v[11] = '{1, 0, 1, 32'h200, 1, 32'h44,  0, 32'h0,   0};
    v[12] = '{1, 0, 1, 32'h300, 1, 32'h44,  0, 32'h0,   0};
    v[13] = '{1, 1, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0};
    v[14] = '{1, 0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0};
    v[15] = '{1, 1, 0, 32'h0,   1, 32'h304, 1, 32'h300, 0};
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    v[16] = '{1, 1, 1, 32'h202, 0, 32'h304, 0, 32'h0,   1};
    v[17] = '{1, 1, 0, 32'h0,   0, 32'h304, 0, 32'h0,   1};
`else
    v[16] = '{1, 1, 1, 32'h202, 1, 32'h200, 0, 32'h0,   0};
    v[17] = '{1, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200, 0};
`endif
    #12 rst = 0;
    chk_out("reset", 0, 32'h100, 0, 32'h0, 0);
    chk("reset.instr", instr, 32'h0);
    chk("reset.pc", instr_pc, 32'h0);
    for (int i = 0; i < 18; i++) begin
      step(v[i].rdy, v[i].ack, v[i].redir, v[i].rpc);
      chk_out($sformatf("vec%0d", i), v[i].req, v[i].addr, v[i].valid, v[i].pc, v[i].mis);
    end
    rst = 1;
    #2 rst = 0;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk_out("pre_rst", 1, 32'h104, 1, 32'h100, 0);
    #3 rst = 1;
    #1;
    chk_out("async_rst", 0, 32'h100, 0, 32'h0, 0);
    chk("async_rst.instr", instr, 32'h0);
    #2 rst = 0;
    step(1, 1, 0, 0);
    chk_out("resume0", 1, 32'h100, 0, 32'h0, 0);
    step(1, 1, 0, 0);
    chk_out("resume1", 1, 32'h104, 1, 32'h100, 0);
    step(1, 1, 0, 0);
    chk_out("resume2", 1, 32'h108, 1, 32'h104, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
